// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared default widths for the adder unit and its sub-blocks.
// Revision : 1.0
// ============================================================================
package adder_pkg;
   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = 8;
endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_comb.sv
`default_nettype none
// ============================================================================
// Module   : adder_comb
// Purpose  : Combinational full-precision unsigned add, carry-out in the MSB.
// Revision : 1.0
// ============================================================================
module adder_comb
   import adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH:0]   sum_o
);

   assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule : adder_comb
`default_nettype wire

// File: rtl/adder_unit.sv
`default_nettype none
// ============================================================================
// Module   : adder_unit
// Purpose  : One-cycle registered adder with result hold and saturating
//            accepted-operation counter.
// Revision : 1.0
// ============================================================================
module adder_unit
   import adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH:0]   sum,
   output logic             out_valid,
   output logic             carry,
   output logic [CNT_W-1:0] op_count
);

   logic [WIDTH:0]   add_res;
   logic [WIDTH:0]   sum_q,   sum_d;
   logic             carry_q, carry_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   adder_comb #(
      .WIDTH (WIDTH)
   ) u_adder_comb (
      .a_i   (a),
      .b_i   (b),
      .sum_o (add_res)
   );

   // Operands only reach the state through the in_valid mux, so idle-cycle
   // garbage on a/b can never disturb the held result.
   always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = 1'b0;
      cnt_d   = cnt_q;
      if (in_valid) begin
         sum_d   = add_res;
         carry_d = add_res[WIDTH];
         valid_d = 1'b1;
         cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sum       = sum_q;
   assign carry     = carry_q;
   assign out_valid = valid_q;
   assign op_count  = cnt_q;

endmodule : adder_unit
`default_nettype wire

// File: tb/adder_stim.sv
`default_nettype none
// ============================================================================
// Module   : adder_stim
// Purpose  : Bench-side operand driver; floats a/b to X whenever not valid.
// Revision : 1.0
// ============================================================================
module adder_stim #(
   parameter int WIDTH = 4
) (
   input  logic             req_valid_i,
   input  logic [WIDTH-1:0] req_a_i,
   input  logic [WIDTH-1:0] req_b_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             in_valid_o
);

   assign in_valid_o = req_valid_i;
   assign a_o        = req_valid_i ? req_a_i : {WIDTH{1'bx}};
   assign b_o        = req_valid_i ? req_b_i : {WIDTH{1'bx}};

endmodule : adder_stim
`default_nettype wire

// File: tb/tb_adder_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_unit
// Purpose  : Self-checking directed bench for adder_unit (WIDTH=4, CNT_W=8).
// Revision : 1.0
// ============================================================================
module tb_adder_unit;

   localparam int W  = 4;
   localparam int CW = 8;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          in_valid;
   logic [W:0]    sum;
   logic          out_valid;
   logic          carry;
   logic [CW-1:0] op_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit rst;
      bit v;
      int a;
      int b;
      int es;
      int ec;
      int ev;
      int ecnt;
   } vec_t;

   vec_t tbl[$];

   adder_stim #(.WIDTH(W)) u_stim (
      .req_valid_i (req_valid),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .a_o         (a),
      .b_o         (b),
      .in_valid_o  (in_valid)
   );

   adder_unit #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .sum       (sum),
      .out_valid (out_valid),
      .carry     (carry),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r, input bit v, input int av, input int bv);
      rst       = r;
      req_valid = v;
      req_a     = W'(av);
      req_b     = W'(bv);
   endtask

   task automatic chk_all(input string tag, input int es, input int ec,
                          input int ev, input int ecnt);
      chk({tag, ".sum"},       int'(sum),       es);
      chk({tag, ".carry"},     int'(carry),     ec);
      chk({tag, ".out_valid"}, int'(out_valid), ev);
      chk({tag, ".op_count"},  int'(op_count),  ecnt);
   endtask

   initial begin
      //                rst v  a   b   sum c v cnt
      tbl.push_back('{1, 1, 5,  3,  0,  0, 0, 0});
      tbl.push_back('{1, 1, 5,  3,  0,  0, 0, 0});
      tbl.push_back('{0, 1, 3,  4,  7,  0, 1, 1});
      tbl.push_back('{0, 0, 9,  9,  7,  0, 0, 1});
      tbl.push_back('{0, 1, 15, 15, 30, 1, 1, 2});
      tbl.push_back('{0, 1, 15, 1,  16, 1, 1, 3});
      tbl.push_back('{0, 1, 0,  0,  0,  0, 1, 4});
      tbl.push_back('{0, 0, 0,  0,  0,  0, 0, 4});
      tbl.push_back('{1, 1, 6,  6,  0,  0, 0, 0});
      tbl.push_back('{0, 1, 1,  2,  3,  0, 1, 1});
      tbl.push_back('{0, 1, 8,  8,  16, 1, 1, 2});
      tbl.push_back('{0, 1, 9,  7,  16, 1, 1, 3});

      drive(1, 1, 5, 3);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].b);
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].es, tbl[i].ec, tbl[i].ev, tbl[i].ecnt);
      end

      // Reset one cycle after issuing 6+6 must wipe the result and the count.
      drive(0, 1, 6, 6);
      step();
      drive(1, 0, 0, 0);
      step();
      chk_all("midrst", 0, 0, 0, 0);
      drive(0, 0, 0, 0);
      step();
      chk_all("midrst_idle", 0, 0, 0, 0);
      drive(0, 1, 2, 3);
      step();
      chk_all("post_rst_first", 5, 0, 1, 1);

      // Exhaustive sweep from a clean counter; saturation at 255.
      drive(1, 0, 0, 0);
      step();
      chk("exh_rst.op_count", int'(op_count), 0);
      for (int i = 0; i < 256; i++) begin
         int av;
         int bv;
         av = i / 16;
         bv = i % 16;
         drive(0, 1, av, bv);
         step();
         chk($sformatf("exh_sum_%0d_%0d", av, bv), int'(sum), av + bv);
         chk($sformatf("exh_carry_%0d_%0d", av, bv), int'(carry), ((av + bv) >= 16) ? 1 : 0);
         chk($sformatf("exh_valid_%0d_%0d", av, bv), int'(out_valid), 1);
         chk($sformatf("exh_cnt_%0d", i), int'(op_count), (i + 1 > 255) ? 255 : i + 1);
      end
      drive(0, 0, 0, 0);
      step();
      chk_all("sat_idle", 30, 1, 0, 255);
      drive(0, 1, 1, 1);
      step();
      chk_all("sat_more", 2, 0, 1, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_adder_unit
`default_nettype wire
